// File: rtl/ram_sched_pkg.sv
// Shared types for the system RAM scheduler: grant tags, loader FIFO entries and RAM read latency.
package ram_sched_pkg;

    typedef enum logic [1:0] {
        G_NONE,
        G_VID,
        G_CPU,
        G_LD
    } grant_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } ld_entry_t;

    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_sched_fifo.sv
// Loader write FIFO: DEPTH entries of address/data, full is evaluated before any same-cycle pop.
module ram_sched_fifo
    import ram_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  ld_entry_t              din,
    input  logic                   pop,
    output ld_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    ld_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_sched.sv
// Single-port system RAM scheduler: video > CPU > loader, fixed 4-cycle request-to-ack latency.
// Loader FIFO and starvation promotion exist only when RAM_SCHED_LOADER_EN is defined.
module ram_sched
    import ram_sched_pkg::*;
#(
    parameter int LD_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    input  logic        ld_wr,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_full,
    output logic        ld_overflow,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_q
);
    grant_t      grant;
    grant_t      tag_issue;
    grant_t      tag_lat [RAM_RD_LAT];
    logic        we_lat  [RAM_RD_LAT];
    grant_t      tag_resp;
    logic        we_resp;
    logic        vid_pend;
    logic [15:0] vid_pend_addr;
    logic        cpu_pend;
    logic        cpu_pend_we;
    logic [15:0] cpu_pend_addr;
    logic [7:0]  cpu_pend_din;
    logic        ld_avail;
    logic        ld_promote;
    ld_entry_t   ld_head;

`ifdef RAM_SCHED_LOADER_EN
    ld_entry_t                   ld_in;
    logic                        ld_empty;
    logic                        ld_pop;
    logic [3:0]                  starve;
    logic [$clog2(LD_DEPTH):0]   ld_count_unused;

    assign ld_in = '{addr: ld_addr, data: ld_data};

    ram_sched_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ld_wr),
        .din   (ld_in),
        .pop   (ld_pop),
        .dout  (ld_head),
        .full  (ld_full),
        .empty (ld_empty),
        .count (ld_count_unused)
    );

    assign ld_avail   = !ld_empty;
    assign ld_promote = (starve == 4'(STARVE_MAX));
    assign ld_pop     = (grant == G_LD);

    always_ff @(posedge clk) begin
        if (!reset || ld_empty || ld_pop) starve <= '0;
        else if (!ld_promote)             starve <= starve + 1'b1;
    end

    // Push drop is judged on the pre-pop full flag, matching the FIFO.
    always_ff @(posedge clk) begin
        if (!reset)                ld_overflow <= 1'b0;
        else if (ld_wr && ld_full) ld_overflow <= 1'b1;
    end
`else
    localparam int CFG_UNUSED = LD_DEPTH + STARVE_MAX;
    logic ld_unused;

    assign ld_unused   = ^{ld_wr, ld_addr, ld_data};
    assign ld_avail    = 1'b0;
    assign ld_promote  = 1'b0;
    assign ld_head     = '0;
    assign ld_full     = 1'b0;
    assign ld_overflow = 1'b0;
`endif

    // A promoted loader only overtakes the CPU; video is always served first.
    always_comb begin
        grant = G_NONE;
        if (vid_pend)                                  grant = G_VID;
        else if (ld_avail && (ld_promote || !cpu_pend)) grant = G_LD;
        else if (cpu_pend)                             grant = G_CPU;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vid_pend      <= 1'b0;
            vid_pend_addr <= '0;
            cpu_pend      <= 1'b0;
            cpu_pend_we   <= 1'b0;
            cpu_pend_addr <= '0;
            cpu_pend_din  <= '0;
        end else begin
            if (grant == G_VID) begin
                vid_pend <= 1'b0;
            end else if (vid_req && !vid_pend) begin
                vid_pend      <= 1'b1;
                vid_pend_addr <= vid_addr;
            end
            if (grant == G_CPU) begin
                cpu_pend <= 1'b0;
            end else if (cpu_req && !cpu_pend) begin
                cpu_pend      <= 1'b1;
                cpu_pend_we   <= cpu_we;
                cpu_pend_addr <= cpu_addr;
                cpu_pend_din  <= cpu_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            tag_issue <= G_NONE;
        end else begin
            ram_en    <= (grant != G_NONE);
            ram_we    <= 1'b0;
            tag_issue <= grant;
            case (grant)
                G_VID: ram_addr <= vid_pend_addr;
                G_CPU: begin
                    ram_addr <= cpu_pend_addr;
                    ram_din  <= cpu_pend_din;
                    ram_we   <= cpu_pend_we;
                end
                G_LD: begin
                    ram_addr <= ld_head.addr;
                    ram_din  <= ld_head.data;
                    ram_we   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tag_resp = tag_lat[RAM_RD_LAT-1];
    assign we_resp  = we_lat[RAM_RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RAM_RD_LAT; i++) begin
                tag_lat[i] <= G_NONE;
                we_lat[i]  <= 1'b0;
            end
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            vid_dout <= 8'h00;
            cpu_dout <= 8'hFF;
        end else begin
            tag_lat[0] <= tag_issue;
            we_lat[0]  <= ram_we;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                tag_lat[i] <= tag_lat[i-1];
                we_lat[i]  <= we_lat[i-1];
            end
            vid_ack <= (tag_resp == G_VID);
            cpu_ack <= (tag_resp == G_CPU);
            if (tag_resp == G_VID)             vid_dout <= ram_q;
            if (tag_resp == G_CPU && !we_resp) cpu_dout <= ram_q;
        end
    end

endmodule

// File: tb/tb_ram_sched.sv
// Directed bench for ram_sched with a behavioural 64 KB synchronous RAM; loader cases follow RAM_SCHED_LOADER_EN.
module tb_ram_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_dout;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        ld_wr;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_full;
    logic        ld_overflow;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_q;

    logic [7:0] mem [65536];
    int checks = 0;
    int failures = 0;
    int cpu_ack_cnt = 0;
    int vid_ack_cnt = 0;
    int wr_cnt = 0;
    int base_c;
    int base_v;
    int base_w;

    always #5 clk = ~clk;

    ram_sched dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (vid_ack),
        .vid_dout    (vid_dout),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_ack     (cpu_ack),
        .cpu_dout    (cpu_dout),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_full     (ld_full),
        .ld_overflow (ld_overflow),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_q       (ram_q)
    );

    // Read-before-write synchronous RAM, one cycle of read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_q <= mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_din;
        end
    end

    always @(negedge clk) begin
        if (cpu_ack) cpu_ack_cnt++;
        if (vid_ack) vid_ack_cnt++;
        if (ram_en && ram_we) wr_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vid_ack"},  vid_ack, 0);
        check({tag, "_cpu_ack"},  cpu_ack, 0);
        check({tag, "_vid_dout"}, vid_dout, 8'h00);
        check({tag, "_cpu_dout"}, cpu_dout, 8'hFF);
        check({tag, "_ram_en"},   ram_en, 0);
        check({tag, "_ram_we"},   ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 16'h0000);
        check({tag, "_ram_din"},  ram_din, 8'h00);
        check({tag, "_ld_full"},  ld_full, 0);
        check({tag, "_ld_ovf"},   ld_overflow, 0);
    endtask

    initial begin
        reset = 1'b0;
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        ld_wr = 0; ld_addr = '0; ld_data = '0;
        ram_q = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'h5A;
        mem[16'h0100] = 8'h11;
        mem[16'h0200] = 8'h22;
        mem[16'h0300] = 8'h33;
        mem[16'h0400] = 8'h44;
        mem[16'hFFFF] = 8'hEE;
        mem[16'h0000] = 8'h0D;

        step(3);
        check_reset_values("rst");
        reset = 1'b1;
        step(2);

        // Single CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        step(); cpu_req = 0;
        check("rd_t1_en", ram_en, 0);
        step();
        check("rd_t2_en", ram_en, 1);
        check("rd_t2_addr", ram_addr, 16'h1234);
        check("rd_t2_we", ram_we, 0);
        step();
        check("rd_t3_ack", cpu_ack, 0);
        check("rd_t3_en", ram_en, 0);
        step();
        check("rd_t4_ack", cpu_ack, 1);
        check("rd_t4_dout", cpu_dout, 8'h5A);
        step();
        check("rd_t5_ack", cpu_ack, 0);
        check("rd_t5_hold", cpu_dout, 8'h5A);

        // CPU write: same latency, read data held
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h4000; cpu_din = 8'hA7;
        step(); cpu_req = 0; cpu_we = 0;
        step();
        check("wr_t2_en", ram_en, 1);
        check("wr_t2_we", ram_we, 1);
        check("wr_t2_addr", ram_addr, 16'h4000);
        check("wr_t2_din", ram_din, 8'hA7);
        step();
        check("wr_t3_we", ram_we, 0);
        step();
        check("wr_t4_ack", cpu_ack, 1);
        check("wr_t4_dout", cpu_dout, 8'h5A);
        check("wr_mem", mem[16'h4000], 8'hA7);
        step();

        // Video and CPU in the same cycle
        vid_req = 1; vid_addr = 16'h0100;
        cpu_req = 1; cpu_addr = 16'h0200;
        step(); vid_req = 0; cpu_req = 0;
        step();
        check("vc_t2_addr", ram_addr, 16'h0100);
        check("vc_t2_en", ram_en, 1);
        step();
        check("vc_t3_addr", ram_addr, 16'h0200);
        check("vc_t3_en", ram_en, 1);
        step();
        check("vc_t4_vack", vid_ack, 1);
        check("vc_t4_vdout", vid_dout, 8'h11);
        check("vc_t4_cack", cpu_ack, 0);
        step();
        check("vc_t5_cack", cpu_ack, 1);
        check("vc_t5_cdout", cpu_dout, 8'h22);
        check("vc_t5_vack", vid_ack, 0);
        step();

        // Duplicate CPU request while pending
        base_c = cpu_ack_cnt;
        cpu_req = 1; cpu_addr = 16'h0300;
        step(); cpu_addr = 16'h0400;
        step(); cpu_req = 0;
        check("dup_t2_addr", ram_addr, 16'h0300);
        step();
        check("dup_t3_en", ram_en, 0);
        step();
        check("dup_t4_ack", cpu_ack, 1);
        check("dup_t4_dout", cpu_dout, 8'h33);
        step(4);
        check("dup_ack_count", cpu_ack_cnt - base_c, 1);

        // Back-to-back issue at the address extremes
        vid_req = 1; vid_addr = 16'hFFFF;
        step(); vid_req = 0; cpu_req = 1; cpu_addr = 16'h0000;
        step(); cpu_req = 0;
        check("b2b_t2_addr", ram_addr, 16'hFFFF);
        check("b2b_t2_en", ram_en, 1);
        step();
        check("b2b_t3_addr", ram_addr, 16'h0000);
        check("b2b_t3_en", ram_en, 1);
        step();
        check("b2b_vack", vid_ack, 1);
        check("b2b_vdout", vid_dout, 8'hEE);
        step();
        check("b2b_cack", cpu_ack, 1);
        check("b2b_cdout", cpu_dout, 8'h0D);
        step(2);

`ifdef RAM_SCHED_LOADER_EN
        // Loader fills an idle slot, no ack
        base_c = cpu_ack_cnt; base_v = vid_ack_cnt;
        ld_wr = 1; ld_addr = 16'hC000; ld_data = 8'h39;
        step(); ld_wr = 0;
        step();
        check("ld1_we", ram_we, 1);
        check("ld1_addr", ram_addr, 16'hC000);
        check("ld1_din", ram_din, 8'h39);
        step(4);
        check("ld1_noack", (cpu_ack_cnt - base_c) + (vid_ack_cnt - base_v), 0);
        check("ld1_mem", mem[16'hC000], 8'h39);

        // Starvation: video/CPU alternate every cycle, loader promoted on cycle 10
        for (int k = 0; k <= 18; k++) begin
            vid_req = (k <= 12) && (k % 2 == 0); vid_addr = 16'h0010;
            cpu_req = (k <= 13) && (k % 2 == 1); cpu_addr = 16'h0020; cpu_we = 0;
            ld_wr = (k == 0); ld_addr = 16'hC100; ld_data = 8'h5C;
            check($sformatf("stv_we_k%0d", k), ram_we, (k == 11));
            check($sformatf("stv_cack_k%0d", k), cpu_ack, (k inside {5, 7, 9, 11, 15, 17}));
            if (k == 11) begin
                check("stv_addr", ram_addr, 16'hC100);
                check("stv_din", ram_din, 8'h5C);
            end
            step();
        end
        vid_req = 0; cpu_req = 0; ld_wr = 0;
        step(3);
        check("stv_mem", mem[16'hC100], 8'h5C);

        // Overflow: 5 pushes while video/CPU occupy the port
        base_w = wr_cnt;
        for (int k = 0; k <= 14; k++) begin
            vid_req = (k <= 4) && (k % 2 == 0); vid_addr = 16'h0010;
            cpu_req = (k <= 5) && (k % 2 == 1); cpu_addr = 16'h0020;
            ld_wr = (k <= 4); ld_addr = 16'hD000 + 16'(k); ld_data = 8'h40 + 8'(k);
            if (k == 3) check("ovf_full_k3", ld_full, 0);
            if (k == 4) begin
                check("ovf_full_k4", ld_full, 1);
                check("ovf_flag_k4", ld_overflow, 0);
            end
            if (k == 5) begin
                check("ovf_full_k5", ld_full, 1);
                check("ovf_flag_k5", ld_overflow, 1);
            end
            if (k == 8) begin
                check("ovf_we_k8", ram_we, 1);
                check("ovf_addr_k8", ram_addr, 16'hD000);
            end
            if (k == 11) begin
                check("ovf_addr_k11", ram_addr, 16'hD003);
                check("ovf_din_k11", ram_din, 8'h43);
            end
            if (k == 12) check("ovf_we_k12", ram_we, 0);
            if (k == 14) begin
                check("ovf_full_k14", ld_full, 0);
                check("ovf_flag_k14", ld_overflow, 1);
            end
            step();
        end
        vid_req = 0; cpu_req = 0; ld_wr = 0;
        check("ovf_wr_count", wr_cnt - base_w, 4);
        check("ovf_mem_d002", mem[16'hD002], 8'h42);
        check("ovf_mem_d004", mem[16'hD004], 8'h00);
`else
        // Loader disabled: strobes have no effect
        base_w = wr_cnt;
        for (int k = 0; k <= 9; k++) begin
            ld_wr = (k <= 4); ld_addr = 16'hD000 + 16'(k); ld_data = 8'h40 + 8'(k);
            check($sformatf("nold_full_k%0d", k), ld_full, 0);
            check($sformatf("nold_ovf_k%0d", k), ld_overflow, 0);
            step();
        end
        ld_wr = 0;
        check("nold_wr_count", wr_cnt - base_w, 0);
        check("nold_mem", mem[16'hD000], 8'h00);
`endif

        // Reset mid-flight: CPU write granted in the reset cycle is lost
        step(2);
        base_c = cpu_ack_cnt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h5000; cpu_din = 8'h99;
        step(); cpu_req = 0; cpu_we = 0; reset = 1'b0;
        step();
        check_reset_values("mid");
        reset = 1'b1;
        step(5);
        check("mid_no_ack", cpu_ack_cnt - base_c, 0);
        check("mid_mem", mem[16'h5000], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
